// File: rtl/clock_divider.sv
// Binary clock divider: a 5-bit free-running counter whose bits are the /2../32 outputs.
// Define CLOCK_DIVIDER_POWERON_INIT_EN to give the counter a power-on value of zero.
module clock_divider (
    input  logic clk,
    input  logic rst,
    output logic divideby2,
    output logic divideby4,
    output logic divideby8,
    output logic divideby16,
    output logic divideby32
);

`ifdef CLOCK_DIVIDER_POWERON_INIT_EN
    // Power-on value lets FPGA builds and reset-free benches count from time 0.
    logic [4:0] cnt = 5'd0;
`else
    logic [4:0] cnt;
`endif

    // NOTE: non-blocking assignment keeps the counter update race-free against other edge-triggered logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 5'd0;
        end else begin
            cnt <= cnt + 5'd1;
        end
    end

    // Outputs come straight from flop bits, so they are glitch-free and rst/clk never reach them combinationally.
    assign divideby2  = cnt[0];
    assign divideby4  = cnt[1];
    assign divideby8  = cnt[2];
    assign divideby16 = cnt[3];
    assign divideby32 = cnt[4];

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: reset, count sequence, wrap, periods/duty, mid-count reset.
// With CLOCK_DIVIDER_POWERON_INIT_EN defined it also checks the reset-free power-on start.
module tb_clock_divider;

    logic clk;
    logic rst;
    logic divideby2, divideby4, divideby8, divideby16, divideby32;
    logic [4:0] outs;

    int n_cmp;
    int n_err;

    time last_rise [5];
    time prev_rise [5];
    time last_fall [5];

    clock_divider dut (
        .clk        (clk),
        .rst        (rst),
        .divideby2  (divideby2),
        .divideby4  (divideby4),
        .divideby8  (divideby8),
        .divideby16 (divideby16),
        .divideby32 (divideby32)
    );

    assign outs = {divideby32, divideby16, divideby8, divideby4, divideby2};

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Edge timestamps of each output for period and duty measurement.
    for (genvar i = 0; i < 5; i++) begin : g_mon
        initial begin
            last_rise[i] = 0;
            prev_rise[i] = 0;
            last_fall[i] = 0;
        end
        always @(posedge outs[i]) begin
            prev_rise[i] = last_rise[i];
            last_rise[i] = $time;
        end
        always @(negedge outs[i]) last_fall[i] = $time;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        time high_t;
        n_cmp = 0;
        n_err = 0;

`ifdef CLOCK_DIVIDER_POWERON_INIT_EN
        rst = 1'b0;
        #1;
        check("poweron_t0", {27'd0, outs}, 32'd0);
        step();
        check("poweron_edge1_div2", {31'd0, divideby2}, 32'd1);
        check("poweron_edge1_outs", {27'd0, outs}, 32'd1);
`endif

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("reset_hold_%0d", i), {27'd0, outs}, 32'd0);
        end

        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            check($sformatf("count_edge_%0d", k), {27'd0, outs}, 32'(k % 32));
        end

        step();
        check("wrap_edge33_div2", {31'd0, divideby2}, 32'd1);
        check("wrap_edge33_outs", {27'd0, outs}, 32'd1);

        // Run to edge 80 so every output has two rises after reset.
        for (int k = 34; k <= 80; k++) step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("period_div%0d", 2 << i),
                  32'(last_rise[i] - prev_rise[i]), 32'(40 << i));
            high_t = (last_fall[i] > last_rise[i]) ? last_fall[i] - last_rise[i]
                                                   : last_fall[i] - prev_rise[i];
            check($sformatf("high_div%0d", 2 << i), 32'(high_t), 32'(20 << i));
        end

        // Edge 80 leaves cnt=16; 29 more edges reach 13.
        for (int k = 0; k < 29; k++) step();
        check("mid_before_reset", {27'd0, outs}, 32'b01101);
        rst = 1'b1;
        step();
        check("mid_reset_edge", {27'd0, outs}, 32'd0);
        rst = 1'b0;
        step();
        check("mid_resume_edge", {27'd0, outs}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
